// File: rtl/rv32i_pkg.sv
// Shared types and opcode decode for the RV32I pipeline control logic.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH) ||
           (opc == OPC_OP_IMM) || (opc == OPC_LOAD) || (opc == OPC_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc, input logic [4:0] rd);
    return (opc != OPC_STORE) && (opc != OPC_BRANCH) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/rv32i_scoreboard.sv
// Three-slot (EX/MEM/WB) destination-register scoreboard with source match.
module rv32i_scoreboard
  import rv32i_pkg::*;
#(
  parameter int WB_BYPASS = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue,
  input  logic [4:0] issue_rd,
  input  logic       id_valid,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hazard,
  output logic       empty
);

  sb_entry_t slot_ex, slot_mem, slot_wb;

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_ex  <= '0;
      slot_mem <= '0;
      slot_wb  <= '0;
    end else begin
      slot_ex  <= issue ? sb_entry_t'{valid: 1'b1, rd: issue_rd} : '0;
      slot_mem <= slot_ex;
      slot_wb  <= slot_mem;
    end
  end

  // With a write-through register file the WB slot can never cause a hazard.
  function automatic logic src_hit(input logic [4:0] rs);
    logic hit;
    hit = (slot_ex.valid && slot_ex.rd == rs) || (slot_mem.valid && slot_mem.rd == rs);
    if (WB_BYPASS == 0)
      hit = hit || (slot_wb.valid && slot_wb.rd == rs);
    return hit && (rs != 5'd0);
  endfunction

  always_comb begin
    hazard = id_valid && ((use_rs1 && src_hit(rs1)) || (use_rs2 && src_hit(rs2)));
    empty  = !slot_ex.valid && !slot_mem.valid && !slot_wb.valid;
  end

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Pipeline stall/flush/redirect control with drain-and-halt sequencing.
// state | meaning
// RUN   | normal issue, stalls only on RAW hazards
// DRAIN | halt requested, bubbling until the scoreboard and flush window empty
// HALT  | pipeline empty and held until resume
module rv32i_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int WB_BYPASS    = 0,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_iw,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic             if_stall,
  output logic             id_stall,
  output logic             id_bubble,
  output logic             if_flush,
  output logic             id_flush,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_state_t state;
  logic [1:0]  flush_cnt;
  logic        hazard, sb_empty, issue, stall, stall_inc;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic        unused_iw;

  assign opc       = id_iw[6:0];
  assign rd        = id_iw[11:7];
  assign rs1       = id_iw[19:15];
  assign rs2       = id_iw[24:20];
  assign unused_iw = ^{id_iw[31:25], id_iw[14:12], ex_target[1:0]};
  assign pc_target = {ex_target[31:2], 2'b00};

  rv32i_scoreboard #(.WB_BYPASS(WB_BYPASS)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .issue_rd (rd),
    .id_valid (id_valid),
    .use_rs1  (uses_rs1(opc)),
    .use_rs2  (uses_rs2(opc)),
    .rs1      (rs1),
    .rs2      (rs2),
    .hazard   (hazard),
    .empty    (sb_empty)
  );

  always_comb begin
    pc_redirect = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    stall       = 1'b0;
    stall_inc   = 1'b0;
    if (ex_redirect) begin
      pc_redirect = 1'b1;
      if_flush    = 1'b1;
      id_flush    = 1'b1;
    end else if (flush_cnt != 2'd0) begin
      if_flush = 1'b1;
    end else if (state != RUN || hazard) begin
      stall     = 1'b1;
      stall_inc = hazard;
    end
  end

  assign if_stall  = stall;
  assign id_stall  = stall;
  assign id_bubble = stall;
  assign issue     = id_valid && !stall && !id_flush && writes_rd(opc, rd);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      halted      <= 1'b0;
      flush_cnt   <= 2'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (ex_redirect)
        flush_cnt <= 2'(FLUSH_CYCLES - 1);
      else if (flush_cnt != 2'd0)
        flush_cnt <= flush_cnt - 2'd1;

      if (stall_inc && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (ex_redirect && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);

      case (state)
        RUN: begin
          if (halt_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!halt_req) begin
            state <= RUN;
          end else if (sb_empty && flush_cnt == 2'd0 && !ex_redirect) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (resume) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Scenario bench for rv32i_hazard_ctrl; a no-bypass and a WB-bypass instance share stimulus.
module tb_rv32i_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset, id_valid, ex_redirect, halt_req, resume;
  logic [31:0] id_iw, ex_target;

  logic        if_stall0, id_stall0, id_bubble0, if_flush0, id_flush0, pc_redirect0, halted0;
  logic [31:0] pc_target0, stall_count0, flush_count0;
  logic        if_stall1, id_stall1, id_bubble1, if_flush1, id_flush1, pc_redirect1, halted1;
  logic [31:0] pc_target1, stall_count1, flush_count1;

  int tests_run = 0;
  int failed    = 0;

  logic [6:0] exp_q[$];
  logic       exp_b_q[$];

  localparam logic [6:0] S = 7'b1110000;

  always #5 clk = ~clk;

  rv32i_hazard_ctrl #(.WB_BYPASS(0), .FLUSH_CYCLES(2), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_iw(id_iw),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .halt_req(halt_req), .resume(resume),
    .if_stall(if_stall0), .id_stall(id_stall0), .id_bubble(id_bubble0), .if_flush(if_flush0),
    .id_flush(id_flush0), .pc_redirect(pc_redirect0), .pc_target(pc_target0), .halted(halted0),
    .stall_count(stall_count0), .flush_count(flush_count0)
  );

  rv32i_hazard_ctrl #(.WB_BYPASS(1), .FLUSH_CYCLES(2), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_iw(id_iw),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .halt_req(halt_req), .resume(resume),
    .if_stall(if_stall1), .id_stall(id_stall1), .id_bubble(id_bubble1), .if_flush(if_flush1),
    .id_flush(id_flush1), .pc_redirect(pc_redirect1), .pc_target(pc_target1), .halted(halted1),
    .stall_count(stall_count1), .flush_count(flush_count1)
  );

  wire [6:0] obs0 = {if_stall0, id_stall0, id_bubble0, if_flush0, id_flush0, pc_redirect0, halted0};

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd1, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic drive(input logic v, input logic [31:0] iw, input logic redir,
                       input logic [31:0] tgt, input logic h, input logic r);
    id_valid    = v;
    id_iw       = iw;
    ex_redirect = redir;
    ex_target   = tgt;
    halt_req    = h;
    resume      = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    apply_reset();
    exp_q.push_back(7'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (obs0 !== e) begin
      failed++;
      $display("FAIL reset_outputs: got %b want %b", obs0, e);
    end
    tests_run++;
    if (stall_count0 !== 32'd0 || flush_count0 !== 32'd0 || pc_target0 !== 32'd0) begin
      failed++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d tgt=%h want 0 0 0",
               stall_count0, flush_count0, pc_target0);
    end
    next_cycle();
  endtask

  task automatic test_raw_hazard();
    logic [6:0] e0[5] = '{7'b0, S, S, S, 7'b0};
    logic       e1[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [6:0] e;
    logic       eb;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 0) ? r_add(5'd5, 5'd1, 5'd2) : r_add(5'd6, 5'd5, 5'd3),
            1'b0, 32'h0, 1'b0, 1'b0);
      exp_q.push_back(e0[i]);
      exp_b_q.push_back(e1[i]);
      @(negedge clk);
      e  = exp_q.pop_front();
      eb = exp_b_q.pop_front();
      tests_run++;
      if (obs0 !== e) begin
        failed++;
        $display("FAIL raw_nobypass cyc%0d: got %b want %b", i, obs0, e);
      end
      tests_run++;
      if (id_stall1 !== eb) begin
        failed++;
        $display("FAIL raw_bypass cyc%0d: got id_stall=%b want %b", i, id_stall1, eb);
      end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++;
    if (stall_count0 !== 32'd3) begin
      failed++;
      $display("FAIL raw_stall_count_nobypass: got %0d want 3", stall_count0);
    end
    tests_run++;
    if (stall_count1 !== 32'd2) begin
      failed++;
      $display("FAIL raw_stall_count_bypass: got %0d want 2", stall_count1);
    end
  endtask

  task automatic test_x0_dest();
    logic [6:0] e;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, (i == 0) ? i_addi(5'd0, 5'd1) : r_add(5'd2, 5'd0, 5'd0),
            1'b0, 32'h0, 1'b0, 1'b0);
      exp_q.push_back(7'b0);
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (obs0 !== e) begin
        failed++;
        $display("FAIL x0_no_stall cyc%0d: got %b want %b", i, obs0, e);
      end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++;
    if (stall_count0 !== 32'd0) begin
      failed++;
      $display("FAIL x0_stall_count: got %0d want 0", stall_count0);
    end
  endtask

  task automatic test_redirect();
    logic [6:0] e0[3] = '{7'b0001110, 7'b0001000, 7'b0};
    logic [6:0] e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, (i == 0), 32'h0000_0043, 1'b0, 1'b0);
      exp_q.push_back(e0[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (obs0 !== e) begin
        failed++;
        $display("FAIL redirect cyc%0d: got %b want %b", i, obs0, e);
      end
      if (i == 0) begin
        tests_run++;
        if (pc_target0 !== 32'h0000_0040) begin
          failed++;
          $display("FAIL redirect_target: got %h want 00000040", pc_target0);
        end
      end
      next_cycle();
    end
    tests_run++;
    if (flush_count0 !== 32'd1) begin
      failed++;
      $display("FAIL redirect_flush_count: got %0d want 1", flush_count0);
    end
  endtask

  task automatic test_redirect_hazard();
    logic [6:0]  e0[4] = '{7'b0, 7'b0001110, 7'b0001000, 7'b0};
    logic [31:0] iw[4];
    logic        v[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [6:0]  e;
    iw[0] = r_add(5'd5, 5'd1, 5'd2);
    iw[1] = r_add(5'd6, 5'd5, 5'd3);
    iw[2] = 32'h0;
    iw[3] = r_add(5'd7, 5'd6, 5'd6);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(v[i], iw[i], (i == 1), 32'h0000_0100, 1'b0, 1'b0);
      exp_q.push_back(e0[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (obs0 !== e) begin
        failed++;
        $display("FAIL redirect_hazard cyc%0d: got %b want %b", i, obs0, e);
      end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++;
    if (stall_count0 !== 32'd0 || flush_count0 !== 32'd1) begin
      failed++;
      $display("FAIL redirect_hazard_counts: got stall=%0d flush=%0d want 0 1",
               stall_count0, flush_count0);
    end
  endtask

  task automatic test_halt();
    logic [6:0] e0[10] = '{7'b0, 7'b0, 7'b0, S, S, S, 7'b1110001, 7'b1110001, 7'b1110001, 7'b0};
    logic       h[10]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [6:0] e;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive((i < 2), (i == 0) ? i_addi(5'd5, 5'd1) : i_addi(5'd6, 5'd2),
            1'b0, 32'h0, h[i], (i == 8));
      exp_q.push_back(e0[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (obs0 !== e) begin
        failed++;
        $display("FAIL halt_drain cyc%0d: got %b want %b", i, obs0, e);
      end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++;
    if (stall_count0 !== 32'd0) begin
      failed++;
      $display("FAIL halt_stall_count: got %0d want 0", stall_count0);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [6:0] e0[5] = '{7'b0, S, S, S, 7'b0};
    logic [6:0] e;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 0) ? r_add(5'd5, 5'd1, 5'd2) : r_add(5'd6, 5'd5, 5'd3),
            1'b0, 32'h0, 1'b0, 1'b0);
      reset = (i == 3) ? 1'b0 : 1'b1;
      if (i != 3) begin
        exp_q.push_back(e0[i]);
        @(negedge clk);
        e = exp_q.pop_front();
        tests_run++;
        if (obs0 !== e) begin
          failed++;
          $display("FAIL reset_mid_stall cyc%0d: got %b want %b", i, obs0, e);
        end
      end
      if (i == 4) begin
        tests_run++;
        if (stall_count0 !== 32'd0 || flush_count0 !== 32'd0) begin
          failed++;
          $display("FAIL reset_mid_stall_counts: got stall=%0d flush=%0d want 0 0",
                   stall_count0, flush_count0);
        end
      end
      next_cycle();
    end
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_raw_hazard();
    test_x0_dest();
    test_redirect();
    test_redirect_hazard();
    test_halt();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
